// File: rtl/minterm_scan_ctrl.sv
// Minterm scan sequencer: walks every input combination of an external SoP bank,
// captures one selected output as a minterm mask and compares it with an expected mask.
module minterm_scan_ctrl #(
  parameter int N_VARS  = 4,
  parameter int N_FUNCS = 5,
  parameter int SETTLE  = 1,
  localparam int N_MINT = 1 << N_VARS,
  localparam int SEL_W  = (N_FUNCS > 1) ? $clog2(N_FUNCS) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [SEL_W-1:0]  i_func_sel,
  input  logic [N_MINT-1:0] i_expected,
  output logic [N_VARS-1:0] o_vars_out,
  input  logic [N_FUNCS-1:0] i_f_in,
  output logic              o_busy,
  output logic              o_done,
  output logic [N_MINT-1:0] o_mask,
  output logic              o_match,
  output logic              o_err_valid,
  output logic [N_VARS-1:0] o_first_err,
  output logic [1:0]        o_state
);

  // Control protocol: i_start is a level sampled only in IDLE (one accepted start per scan);
  // o_done is a single-cycle pulse and results stay stable until the next accepted start.

  localparam int CNT_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_C  = CNT_W'(SETTLE);
  localparam logic [N_VARS-1:0] LAST_IDX  = '1;
  localparam logic [SEL_W:0]    N_FUNCS_C = (SEL_W + 1)'(N_FUNCS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_VARS-1:0]   r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [SEL_W-1:0]    r_sel;
  logic [N_MINT-1:0]   r_exp;
  logic [N_MINT-1:0]   r_mask;
  logic                r_match;
  logic                r_err_valid;
  logic [N_VARS-1:0]   r_first_err;

  logic                w_start_acc;
  logic                w_sample;
  logic                w_last;
  logic                w_bit;
  logic [N_MINT-1:0]   w_mask_nxt;
  logic [SEL_W-1:0]    w_sel_safe;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_sample    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort beats a pending sample so the partial mask only holds fully settled minterms.
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == SETTLE_C) begin
          w_sample = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_last      = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_bit              = i_f_in[r_sel];
    w_mask_nxt         = r_mask;
    w_mask_nxt[r_idx]  = w_bit;
    w_sel_safe         = ({1'b0, i_func_sel} < N_FUNCS_C) ? i_func_sel : '0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_exp       <= '0;
      r_mask      <= '0;
      r_match     <= 1'b0;
      r_err_valid <= 1'b0;
      r_first_err <= '0;
    end else if (w_start_acc) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_sel       <= w_sel_safe;
      r_exp       <= i_expected;
      r_mask      <= '0;
      r_match     <= 1'b0;
      r_err_valid <= 1'b0;
      r_first_err <= '0;
    end else if (r_state == ST_RUN && !i_abort) begin
      if (w_sample) begin
        r_mask <= w_mask_nxt;
        if ((w_bit != r_exp[r_idx]) && !r_err_valid) begin
          r_first_err <= r_idx;
          r_err_valid <= 1'b1;
        end
        // The final index is kept on vars_out after the scan.
        if (w_last) begin
          r_match <= (w_mask_nxt == r_exp);
        end else begin
          r_idx <= r_idx + 1'b1;
          r_cnt <= '0;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_vars_out  = r_idx;
  assign o_busy      = (r_state == ST_RUN);
  assign o_done      = (r_state == ST_DONE);
  assign o_mask      = r_mask;
  assign o_match     = r_match;
  assign o_err_valid = r_err_valid;
  assign o_first_err = r_first_err;
  assign o_state     = r_state;

endmodule

// File: tb/tb_minterm_scan_ctrl.sv
// Bench for minterm_scan_ctrl: a 4-variable/SETTLE=1 instance and a 3-variable/SETTLE=0
// instance, each driven by a behavioural SoP bank and checked against a mask-level model.
module tb_minterm_scan_ctrl;

  localparam int SETTLE4 = 1;
  localparam int N_MINT4 = 16;
  localparam int NONE    = 1000;
  localparam int TIMEOUT = 100;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 4-variable instance
  logic        start4, abort4;
  logic [2:0]  func_sel4;
  logic [15:0] expected4;
  logic [3:0]  vars4;
  logic [4:0]  f_in4;
  logic        busy4, done4, match4, err4;
  logic [15:0] mask4;
  logic [3:0]  first4;
  logic [1:0]  state4;

  // 3-variable, SETTLE=0 instance
  logic        start3, abort3;
  logic        func_sel3;
  logic [7:0]  expected3;
  logic [2:0]  vars3;
  logic [1:0]  f_in3;
  logic        busy3, done3, match3, err3;
  logic [7:0]  mask3;
  logic [2:0]  first3;
  logic [1:0]  state3;

  // SoP bank truth tables: bit i = f(minterm i)
  logic [15:0] tbl [5];
  logic [7:0]  fn3;

  always_comb begin
    for (int k = 0; k < 5; k++) f_in4[k] = tbl[k][vars4];
    f_in3[0] = fn3[vars3];
    f_in3[1] = ~fn3[vars3];
  end

  minterm_scan_ctrl #(.N_VARS(4), .N_FUNCS(5), .SETTLE(SETTLE4)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start4), .i_abort(abort4),
    .i_func_sel(func_sel4), .i_expected(expected4), .o_vars_out(vars4),
    .i_f_in(f_in4), .o_busy(busy4), .o_done(done4), .o_mask(mask4),
    .o_match(match4), .o_err_valid(err4), .o_first_err(first4), .o_state(state4)
  );

  minterm_scan_ctrl #(.N_VARS(3), .N_FUNCS(2), .SETTLE(0)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_start(start3), .i_abort(abort3),
    .i_func_sel(func_sel3), .i_expected(expected3), .o_vars_out(vars3),
    .i_f_in(f_in3), .o_busy(busy3), .o_done(done3), .o_mask(mask3),
    .o_match(match3), .o_err_valid(err3), .o_first_err(first3), .o_state(state3)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Lowest minterm below n where the captured function differs from the expectation.
  function automatic void ref_errors(input logic [15:0] m, input logic [15:0] e, input int n,
                                     output bit ev, output int fe);
    ev = 1'b0;
    fe = 0;
    for (int i = n - 1; i >= 0; i--) begin
      if (m[i] != e[i]) begin
        ev = 1'b1;
        fe = i;
      end
    end
  endfunction

  // driver: one scan on the 4-variable instance with optional disturbances
  task automatic scan4(input logic [2:0] sel, input logic [15:0] expv, input int poke_at,
                       input int abort_at, input int reset_at, input bit abort_on_start);
    logic [15:0] m, keep, want;
    int edges, n_s, fe;
    bit ev, aborted, was_reset, saw_done;
    m = tbl[(sel < 3'd5) ? sel : 3'd0];
    aborted = 1'b0;
    was_reset = 1'b0;
    @(negedge clk);
    start4 = 1'b1; func_sel4 = sel; expected4 = expv; abort4 = abort_on_start;
    @(negedge clk);
    start4 = 1'b0; abort4 = 1'b0;
    for (edges = 0; edges < TIMEOUT; edges++) begin
      if (edges == abort_at + 1) begin
        aborted = 1'b1;
        abort4 = 1'b0;
        break;
      end
      if (done4) break;
      if (edges == reset_at) begin
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_vars", vars4, 0);
        check("rst_mask", mask4, 0);
        check("rst_match", match4, 0);
        check("rst_err_valid", err4, 0);
        check("rst_first_err", first4, 0);
        rst = 1'b0;
        was_reset = 1'b1;
        @(negedge clk);
        break;
      end
      check("busy", busy4, 1);
      check("vars_out", vars4, edges / (SETTLE4 + 1));
      start4 = (edges == poke_at);
      if (edges == poke_at) begin
        func_sel4 = sel ^ 3'd1;
        expected4 = ~expv;
      end
      abort4 = (edges == abort_at);
      @(negedge clk);
    end
    if (!was_reset) begin
      n_s = aborted ? abort_at / (SETTLE4 + 1) : N_MINT4;
      keep = (n_s >= 16) ? 16'hFFFF : 16'((32'd1 << n_s) - 1);
      exp_q.push_back(m & keep);
      ref_errors(m, expv, n_s, ev, fe);
      want = exp_q.pop_front();
      if (aborted) begin
        check("abort_busy", busy4, 0);
        check("abort_done", done4, 0);
        check("part_mask", mask4, want);
        check("part_match", match4, 0);
        check("part_err_valid", err4, ev);
        check("part_first_err", first4, fe);
        saw_done = 1'b0;
        repeat (40) begin
          @(negedge clk);
          saw_done = saw_done | done4;
        end
        check("abort_no_done", saw_done, 0);
      end else begin
        check("latency", edges, N_MINT4 * (SETTLE4 + 1));
        check("done", done4, 1);
        check("busy_in_done", busy4, 0);
        check("mask", mask4, want);
        check("match", match4, m == expv);
        check("err_valid", err4, ev);
        check("first_err", first4, fe);
        check("vars_last", vars4, 15);
        @(negedge clk);
        check("done_pulse", done4, 0);
        check("idle_busy", busy4, 0);
        check("held_mask", mask4, want);
        check("held_match", match4, m == expv);
      end
    end
  endtask

  // driver: one scan on the 3-variable SETTLE=0 instance
  task automatic scan3(input logic sel, input logic [7:0] expv);
    logic [7:0] m;
    int edges, fe;
    bit ev;
    m = sel ? ~fn3 : fn3;
    @(negedge clk);
    start3 = 1'b1; func_sel3 = sel; expected3 = expv;
    @(negedge clk);
    start3 = 1'b0;
    for (edges = 0; edges < TIMEOUT; edges++) begin
      if (done3) break;
      check("busy3", busy3, 1);
      check("vars3", vars3, edges);
      @(negedge clk);
    end
    ref_errors({8'h00, m}, {8'h00, expv}, 8, ev, fe);
    check("latency3", edges, 8);
    check("done3", done3, 1);
    check("mask3", mask3, m);
    check("match3", match3, m == expv);
    check("err_valid3", err3, ev);
    check("first_err3", first3, fe);
    @(negedge clk);
    check("done3_pulse", done3, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    logic [2:0]  sel;
    logic [15:0] m, e;
    rst = 1'b1;
    start4 = 1'b0; abort4 = 1'b0; func_sel4 = '0; expected4 = '0;
    start3 = 1'b0; abort3 = 1'b0; func_sel3 = 1'b0; expected3 = '0;
    tbl[0] = 16'($urandom);
    tbl[1] = 16'($urandom);
    tbl[2] = 16'hA0AE;   // SoP(1,2,3,5,7,13,15)
    tbl[3] = 16'h5516;   // SoP(1,2,4,8,10,12,14)
    tbl[4] = 16'h41C5;   // SoP(0,2,6,7,8,14)
    fn3    = 8'hC6;      // SoP(1,2,6,7)
    #3;
    check("reset_busy", busy4, 0);
    check("reset_done", done4, 0);
    check("reset_vars", vars4, 0);
    check("reset_mask", mask4, 0);
    check("reset_match", match4, 0);
    check("reset_err_valid", err4, 0);
    check("reset_first_err", first4, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    scan4(3'd2, 16'hA0AE, NONE, NONE, NONE, 1'b0);
    scan4(3'd3, 16'h5516, NONE, NONE, NONE, 1'b0);
    scan4(3'd4, 16'h41C5, NONE, NONE, NONE, 1'b0);
    scan4(3'd2, 16'hA0AF, NONE, NONE, NONE, 1'b0);
    scan4(3'd2, 16'h20AE, NONE, NONE, NONE, 1'b0);
    scan4(3'd2, 16'hA0AE, 5, NONE, NONE, 1'b0);
    scan4(3'd3, 16'h5516, NONE, 10, NONE, 1'b0);
    scan4(3'd2, 16'hA0A6, NONE, 10, NONE, 1'b0);
    scan4(3'd2, 16'hA2AE, NONE, 10, NONE, 1'b0);
    scan4(3'd4, 16'h41C5, NONE, NONE, NONE, 1'b1);
    scan4(3'd2, 16'hA0AE, NONE, NONE, 7, 1'b0);
    scan4(3'd2, 16'hA0AE, NONE, NONE, NONE, 1'b0);
    scan4(3'd6, tbl[0], NONE, NONE, NONE, 1'b0);
    scan4(3'd7, 16'h0000, NONE, NONE, NONE, 1'b0);

    for (int r = 0; r < 9; r++) begin
      tbl[0] = 16'($urandom);
      tbl[1] = 16'($urandom);
      sel = 3'($urandom_range(0, 7));
      m = tbl[(sel < 3'd5) ? sel : 3'd0];
      case ($urandom_range(0, 2))
        0:       e = m;
        1:       e = m ^ (16'd1 << $urandom_range(0, 15));
        default: e = 16'($urandom);
      endcase
      if (r % 3 == 2) scan4(sel, e, NONE, $urandom_range(1, 30), NONE, 1'b0);
      else            scan4(sel, e, NONE, NONE, NONE, 1'b0);
    end

    scan3(1'b0, 8'hC6);
    scan3(1'b1, 8'h39);
    scan3(1'b0, 8'hC2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/minterm_scan_ctrl.md
Name: minterm_scan_ctrl

Overview:
- Sequencer that sweeps every input combination of a combinational logic unit under test, one per minterm.
- Samples the selected output bit of that unit for each combination and builds the function's minterm mask.
- Compares the captured mask against an expected SoP mask and reports match, plus the first failing minterm.
- Sits between a host/bench controller and a bank of up to N_FUNCS SoP functions that share the same input variables.

Parameters:
- N_VARS, 4, number of input variables; the sweep covers 2^N_VARS minterms.
- N_FUNCS, 5, number of function outputs on f_in.
- SETTLE, 1, extra cycles each combination is held before sampling (0 allowed).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a scan; accepted only in IDLE.
- abort  in  1  synchronous cancel of a running scan.
- func_sel  in  $clog2(N_FUNCS)  function to scan; latched when start is accepted.
- expected  in  2^N_VARS  expected minterm mask, bit i = f(i); latched when start is accepted.
- vars_out  out  N_VARS  drives the variables of the unit under test; MSB = first variable (x).
- f_in  in  N_FUNCS  function outputs from the unit under test.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when a scan completes.
- mask  out  2^N_VARS  captured minterm mask.
- match  out  1  mask == expected; valid from done until the next accepted start.
- err_valid  out  1  at least one mismatch seen in the current or last scan.
- first_err  out  N_VARS  lowest mismatching minterm index; valid when err_valid=1.

Behaviour:
- Reset (async, any state): state=IDLE, vars_out=0, busy=0, done=0, mask=0, match=0, err_valid=0, first_err=0; internal idx=0, cnt=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches func_sel and expected, clears mask, err_valid, first_err and match, sets idx=0 and cnt=0, then enters RUN.
  - An out-of-range func_sel is treated as 0.
- RUN:
  - vars_out = idx (registered) throughout.
  - When cnt<SETTLE: cnt increments.
  - When cnt==SETTLE: mask[idx] <= f_in[sel].
  - On that same edge, if f_in[sel] != expected[idx] and err_valid=0: first_err<=idx and err_valid<=1.
  - After sampling, if idx==2^N_VARS-1 go to DONE; otherwise idx increments and cnt resets to 0.
- Per-minterm time is SETTLE+1 cycles. Start accepted at edge 0 -> RUN for 2^N_VARS*(SETTLE+1) cycles -> DONE for 1 cycle.
- DONE: done=1 and busy=0; match is registered from the full captured mask. Next cycle returns to IDLE, with vars_out left at the last index.
- Boundary conditions:
  - start while busy: ignored, and latched values are not disturbed.
  - start and abort in the same IDLE cycle: start wins.
  - abort in RUN: return to IDLE next edge with no done pulse; mask and err flags are kept as partial results and match stays 0.
  - abort in DONE: ignored, done still pulses.
  - expected and func_sel changing mid-scan: no effect.
  - idx never wraps within a scan.
  - SETTLE=0: one minterm per cycle.
  - Reset mid-scan: immediate return to reset values, no done.
- mask, match, err_valid and first_err are held in IDLE until the next accepted start.

Test Plan:
- N_VARS=4, SETTLE=1; unit = SoP(1,2,3,5,7,13,15) on f_in[2]; func_sel=2, expected=16'hA0AE; pulse start -> busy for 32 cycles, done at cycle 33, mask=16'hA0AE, match=1, err_valid=0.
- Same setup, func_sel=3 with SoP(1,2,4,8,10,12,14), expected=16'h5516 -> mask=16'h5516, match=1. Then func_sel=4 with SoP(0,2,6,7,8,14), expected=16'h41C5 -> mask=16'h41C5, match=1.
- Scan function c with expected=16'hA0AF -> mask=16'hA0AE, match=0, err_valid=1, first_err=0. Expected=16'h20AE -> first_err=15.
- N_VARS=3, SETTLE=0; unit = SoP(1,2,6,7), expected=8'hC6 -> done exactly 9 cycles after the start edge, vars_out sequence 0..7 one per cycle, match=1.
- Assert abort after 10 RUN cycles -> IDLE next edge, no done pulse, busy=0. start during RUN -> ignored, completion time unchanged.
- Assert async reset mid-RUN between clock edges -> outputs zero immediately. A fresh start afterwards completes normally with the correct mask.
